// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory and decode-side handshake bundle for fetch_unit
interface fetch_unit_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [3:0]         opcode;
    logic [ADDR_W-1:0]  instr_pc;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;

    // fetch unit side
    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output instr_valid, instr, opcode, instr_pc,
        input  instr_ready,
        input  redirect, redirect_pc
    );

    // memory / decode / execute side
    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  instr_valid, instr, opcode, instr_pc,
        output instr_ready,
        output redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and instruction fetcher; FETCH_PREFETCH_EN adds a skid slot
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic            clk,
    input logic            reset,
    fetch_unit_if.master   bus
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               req_q;
    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  instr_pc_q;

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[INSTR_W-1 -: 4];
    assign bus.instr_pc    = instr_pc_q;

`ifdef FETCH_PREFETCH_EN
    logic               skid_valid_q;
    logic [INSTR_W-1:0] skid_instr_q;
    logic [ADDR_W-1:0]  skid_pc_q;
    logic               transfer;
    logic               ack_live;
    logic               out_nv;
    logic               skid_nv;
    logic [1:0]         occ_d;
    logic [ADDR_W-1:0]  pc_d;

    // Slot occupancy after this edge decides whether another request may go out
    always_comb begin
        transfer = valid_q & bus.instr_ready & ~bus.redirect;
        ack_live = req_q & bus.imem_ack & (state_q != DROP);
        out_nv   = 1'b0;
        skid_nv  = 1'b0;
        if (transfer | ~valid_q) begin
            out_nv  = skid_valid_q | ack_live;
            skid_nv = skid_valid_q & ack_live;
        end else begin
            out_nv  = 1'b1;
            skid_nv = skid_valid_q | ack_live;
        end
        occ_d = {1'b0, out_nv} + {1'b0, skid_nv};
        pc_d  = ack_live ? pc_q + PC_ONE : pc_q;
    end

    // Fetch pipeline with output register plus one skid entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            instr_q      <= '0;
            instr_pc_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else if (state_q == IDLE) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
            if (bus.redirect) begin
                pc_q   <= bus.redirect_pc;
                addr_q <= bus.redirect_pc;
            end else begin
                addr_q <= pc_q;
            end
        end else if (bus.redirect) begin
            pc_q         <= bus.redirect_pc;
            valid_q      <= 1'b0;
            skid_valid_q <= 1'b0;
            if (req_q && !bus.imem_ack) begin
                // in-flight request cannot be withdrawn; swallow its data later
                state_q <= DROP;
            end else begin
                state_q <= FETCH;
                req_q   <= 1'b1;
                addr_q  <= bus.redirect_pc;
            end
        end else if (state_q == DROP) begin
            if (bus.imem_ack) begin
                state_q <= FETCH;
                addr_q  <= pc_q;
            end
        end else begin
            if (transfer || !valid_q) begin
                if (skid_valid_q) begin
                    instr_q      <= skid_instr_q;
                    instr_pc_q   <= skid_pc_q;
                    skid_valid_q <= 1'b0;
                end else if (ack_live) begin
                    instr_q    <= bus.imem_rdata;
                    instr_pc_q <= addr_q;
                end
                valid_q <= out_nv;
            end else if (ack_live) begin
                skid_instr_q <= bus.imem_rdata;
                skid_pc_q    <= addr_q;
                skid_valid_q <= 1'b1;
            end
            pc_q <= pc_d;
            if (req_q && !bus.imem_ack) begin
                req_q <= 1'b1;
            end else if (occ_d <= 2'd1) begin
                req_q  <= 1'b1;
                addr_q <= pc_d;
            end else begin
                req_q <= 1'b0;
            end
        end
    end
`else
    // Single-slot fetch FSM; every output comes straight from a register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                    if (bus.redirect) begin
                        pc_q   <= bus.redirect_pc;
                        addr_q <= bus.redirect_pc;
                    end else begin
                        addr_q <= pc_q;
                    end
                end
                FETCH: begin
                    if (bus.redirect) begin
                        pc_q <= bus.redirect_pc;
                        if (bus.imem_ack) begin
                            addr_q <= bus.redirect_pc;
                        end else begin
                            // keep old address on the bus until its ack arrives
                            state_q <= DROP;
                        end
                    end else if (bus.imem_ack) begin
                        instr_q    <= bus.imem_rdata;
                        instr_pc_q <= pc_q;
                        valid_q    <= 1'b1;
                        pc_q       <= pc_q + PC_ONE;
                        req_q      <= 1'b0;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.redirect) begin
                        valid_q <= 1'b0;
                        pc_q    <= bus.redirect_pc;
                        addr_q  <= bus.redirect_pc;
                        req_q   <= 1'b1;
                        state_q <= FETCH;
                    end else if (bus.instr_ready) begin
                        valid_q <= 1'b0;
                        addr_q  <= pc_q;
                        req_q   <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                DROP: begin
                    if (bus.redirect) begin
                        pc_q <= bus.redirect_pc;
                    end
                    if (bus.imem_ack) begin
                        state_q <= FETCH;
                        addr_q  <= bus.redirect ? bus.redirect_pc : pc_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] ins;
    } want_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   mem_en = 0;
    int   lat = 0;
    int   wait_cnt = 0;
    logic force_ack = 1'b0;
    want_t want_q[$];
    int    xfer_cyc[$];

    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus();

    fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(8'h00)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return {a[3:0], 4'hA, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_want(input logic [7:0] a);
        want_t w;
        w.pc  = a;
        w.ins = mem_word(a);
        want_q.push_back(w);
    endtask

    always @(posedge clk) cyc++;

    // memory model: acks after lat waiting cycles, data derived from the address
    always @(negedge clk) begin
        if (mem_en != 0 && bus.imem_req) begin
            if (wait_cnt >= lat) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = mem_word(bus.imem_addr);
                wait_cnt       = 0;
            end else begin
                bus.imem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            bus.imem_ack   = force_ack;
            bus.imem_rdata = force_ack ? 16'hDEAD : 16'h0000;
            wait_cnt       = 0;
        end
    end

    // monitor: every accepted beat must be the next scoreboard entry
    always @(negedge clk) begin
        if (!reset && bus.instr_valid && bus.instr_ready && !bus.redirect) begin
            xfer_cyc.push_back(cyc);
            if (want_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_xfer: got pc 0x%0h expected no transfer", bus.instr_pc);
            end else begin
                want_t w;
                w = want_q.pop_front();
                check("xfer_pc", bus.instr_pc, w.pc);
                check("xfer_instr", bus.instr, w.ins);
                check("xfer_opcode", bus.opcode, w.ins[15:12]);
            end
        end
    end

    initial begin
        int found;
        int spacing;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", bus.imem_req, 0);
        check("rst_addr", bus.imem_addr, 8'h00);
        check("rst_valid", bus.instr_valid, 0);
        check("rst_instr", bus.instr, 16'h0);
        check("rst_opcode", bus.opcode, 4'h0);
        check("rst_instr_pc", bus.instr_pc, 8'h00);

        // release: IDLE in cycle 0, request in cycle 1
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("idle_req", bus.imem_req, 0);
        @(negedge clk);
        check("first_req", bus.imem_req, 1);
        check("first_addr", bus.imem_addr, 8'h00);

        // reset mid-fetch with ack withheld
        @(posedge clk); #1 reset = 1'b1;
        #1;
        check("midrst_req", bus.imem_req, 0);
        check("midrst_valid", bus.instr_valid, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        force_ack = 1'b1;
        @(negedge clk);
        check("late_ack_idle_req", bus.imem_req, 0);
        @(posedge clk); #1 force_ack = 1'b0;
        @(negedge clk);
        check("late_ack_valid", bus.instr_valid, 0);
        check("late_ack_req", bus.imem_req, 1);
        check("late_ack_addr", bus.imem_addr, 8'h00);

        // zero-wait stream, ready high, stop accepting at 0x03
        @(posedge clk); #1;
        for (int a = 0; a < 4; a++) push_want(8'(a));
        xfer_cyc.delete();
        mem_en = 1;
        lat = 0;
        bus.instr_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.instr_valid && bus.instr_pc == 8'h03) begin
                bus.instr_ready = 1'b0;
                found = 1;
                break;
            end
        end
        check("reach_pc3", found, 1);
`ifdef FETCH_PREFETCH_EN
        spacing = 1;
`else
        spacing = 2;
`endif
        check("xfer_count", xfer_cyc.size(), 3);
        if (xfer_cyc.size() >= 3) begin
            check("spacing_0_1", xfer_cyc[1] - xfer_cyc[0], spacing);
            check("spacing_1_2", xfer_cyc[2] - xfer_cyc[1], spacing);
        end

        // stall for 5 cycles: output held, no new request
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", bus.instr_valid, 1);
            check("hold_pc", bus.instr_pc, 8'h03);
            check("hold_instr", bus.instr, mem_word(8'h03));
`ifndef FETCH_PREFETCH_EN
            check("hold_no_req", bus.imem_req, 0);
`endif
        end
        @(posedge clk); #1;
        lat = 3;
        bus.instr_ready = 1'b1;
        push_want(8'h04);
        push_want(8'h40);
        push_want(8'h41);
        push_want(8'hFE);
        push_want(8'hFF);
        push_want(8'h00);
        push_want(8'h01);
`ifndef FETCH_PREFETCH_EN
        @(negedge clk);
        @(negedge clk);
        check("after_hold_req", bus.imem_req, 1);
        check("after_hold_addr", bus.imem_addr, 8'h04);
`endif

        // slow memory, redirect one cycle after request to 0x05
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.imem_req && bus.imem_addr == 8'h05) begin
                found = 1;
                break;
            end
        end
        check("reach_req5", found, 1);
        @(posedge clk); #1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'h40;
        @(posedge clk); #1;
        bus.redirect = 1'b0;
        @(negedge clk);
        check("drop_req_a", bus.imem_req, 1);
        check("drop_addr_a", bus.imem_addr, 8'h05);
        @(negedge clk);
        check("drop_req_b", bus.imem_req, 1);
        check("drop_addr_b", bus.imem_addr, 8'h05);
        @(negedge clk);
        check("redir_req", bus.imem_req, 1);
        check("redir_addr", bus.imem_addr, 8'h40);

        // zero-wait again; redirect coincident with ack of 0x42
        @(posedge clk); #1 lat = 0;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.imem_req && bus.imem_addr == 8'h42) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("reach_req42", found, 1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 8'hFE;
        @(posedge clk); #1;
        bus.redirect = 1'b0;
        @(negedge clk);
        check("coinc_req", bus.imem_req, 1);
        check("coinc_addr", bus.imem_addr, 8'hFE);

        // wrap past 0xFF, stop accepting at 0x02
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.imem_req && bus.imem_addr == 8'h00) found = 1;
            if (bus.instr_valid && bus.instr_pc == 8'h02) begin
                bus.instr_ready = 1'b0;
                break;
            end
        end
        check("wrap_addr_seen", found, 1);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", want_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
